// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the MIPS pipeline hazard/forwarding control.
package mips_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one ID-stage source register (EX > MEM > WB > RF).
module fwd_select
    import mips_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       src_use,
    input  logic [4:0] ex_rd,
    input  logic       ex_rf_enable,
    input  logic       ex_load,
    input  logic [4:0] mem_rd,
    input  logic       mem_rf_enable,
    input  logic [4:0] wb_rd,
    input  logic       wb_rf_enable,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (src_use && (src != REG_ZERO)) begin
            // Load data is not ready in EX; the load-use stall handles it instead.
            if (ex_rf_enable && !ex_load && (ex_rd == src)) begin
                sel = FWD_EX;
            end else if (mem_rf_enable && (mem_rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_rf_enable && (wb_rd == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: load-use and HI/LO stalls, forwarding selects,
// mult/div occupancy FSM and a saturating stall-cycle counter.
module hazard_stall_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ID_VALID,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic             ID_RS_USE,
    input  logic             ID_RT_USE,
    input  logic             ID_MD_START,
    input  logic             ID_HILO_READ,
    input  logic [4:0]       EX_RD,
    input  logic             EX_RF_ENABLE,
    input  logic             EX_LOAD_INSTR,
    input  logic [4:0]       MEM_RD,
    input  logic             MEM_RF_ENABLE,
    input  logic [4:0]       WB_RD,
    input  logic             WB_RF_ENABLE,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             ID_EX_BUBBLE,
    output logic [1:0]       MX1_SEL,
    output logic [1:0]       MX2_SEL,
    output logic             MD_BUSY,
    output logic [CNT_W-1:0] STALL_CYCLES
);

    localparam logic [7:0] MD_LAT_INIT = 8'(MD_LATENCY);

    md_state_e        state_q, state_d;
    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic       ex_hits_rs, ex_hits_rt;
    logic       load_use, md_stall, stall, accept;
    logic [1:0] mx1_raw, mx2_raw;

    fwd_select u_fwd_rs (
        .src           (ID_RS),
        .src_use       (ID_RS_USE),
        .ex_rd         (EX_RD),
        .ex_rf_enable  (EX_RF_ENABLE),
        .ex_load       (EX_LOAD_INSTR),
        .mem_rd        (MEM_RD),
        .mem_rf_enable (MEM_RF_ENABLE),
        .wb_rd         (WB_RD),
        .wb_rf_enable  (WB_RF_ENABLE),
        .sel           (mx1_raw)
    );

    fwd_select u_fwd_rt (
        .src           (ID_RT),
        .src_use       (ID_RT_USE),
        .ex_rd         (EX_RD),
        .ex_rf_enable  (EX_RF_ENABLE),
        .ex_load       (EX_LOAD_INSTR),
        .mem_rd        (MEM_RD),
        .mem_rf_enable (MEM_RF_ENABLE),
        .wb_rd         (WB_RD),
        .wb_rf_enable  (WB_RF_ENABLE),
        .sel           (mx2_raw)
    );

    assign MD_BUSY = (state_q == mips_ctrl_pkg::MD_BUSY);

    assign ex_hits_rs = EX_RF_ENABLE && (EX_RD != REG_ZERO) && (EX_RD == ID_RS) && ID_RS_USE;
    assign ex_hits_rt = EX_RF_ENABLE && (EX_RD != REG_ZERO) && (EX_RD == ID_RT) && ID_RT_USE;

    assign load_use = ID_VALID && EX_LOAD_INSTR && (ex_hits_rs || ex_hits_rt);
    assign md_stall = ID_VALID && MD_BUSY && (ID_HILO_READ || ID_MD_START);
    assign stall    = load_use || md_stall;
    assign accept   = ID_VALID && ID_MD_START && !stall;

    // Reset forces the pipeline to free-run with no bubbles or forwarding.
    assign PC_LE        = Reset || !stall;
    assign IF_ID_LE     = Reset || !stall;
    assign ID_EX_BUBBLE = !Reset && stall;
    assign MX1_SEL      = Reset ? FWD_RF : mx1_raw;
    assign MX2_SEL      = Reset ? FWD_RF : mx2_raw;

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            mips_ctrl_pkg::MD_IDLE: begin
                if (accept) begin
                    state_d  = mips_ctrl_pkg::MD_BUSY;
                    md_cnt_d = MD_LAT_INIT;
                end
            end
            mips_ctrl_pkg::MD_BUSY: begin
                if (md_cnt_q == 8'd1) begin
                    state_d  = mips_ctrl_pkg::MD_IDLE;
                    md_cnt_d = 8'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d  = mips_ctrl_pkg::MD_IDLE;
                md_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= mips_ctrl_pkg::MD_IDLE;
            md_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign STALL_CYCLES = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: two controller instances against a cycle-count based reference model.
module tb_hazard_stall_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       id_valid, id_rs_use, id_rt_use, id_md_start, id_hilo_read;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_rf_enable, ex_load_instr, mem_rf_enable, wb_rf_enable;

    logic        pc_le [2];
    logic        if_id_le [2];
    logic        bubble [2];
    logic [1:0]  mx1 [2];
    logic [1:0]  mx2 [2];
    logic        md_busy [2];
    logic [31:0] sc0;
    logic [3:0]  sc1;

    hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(32)) dut (
        .Clk(clk), .Reset(reset), .ID_VALID(id_valid), .ID_RS(id_rs), .ID_RT(id_rt),
        .ID_RS_USE(id_rs_use), .ID_RT_USE(id_rt_use), .ID_MD_START(id_md_start),
        .ID_HILO_READ(id_hilo_read), .EX_RD(ex_rd), .EX_RF_ENABLE(ex_rf_enable),
        .EX_LOAD_INSTR(ex_load_instr), .MEM_RD(mem_rd), .MEM_RF_ENABLE(mem_rf_enable),
        .WB_RD(wb_rd), .WB_RF_ENABLE(wb_rf_enable), .PC_LE(pc_le[0]), .IF_ID_LE(if_id_le[0]),
        .ID_EX_BUBBLE(bubble[0]), .MX1_SEL(mx1[0]), .MX2_SEL(mx2[0]), .MD_BUSY(md_busy[0]),
        .STALL_CYCLES(sc0)
    );

    hazard_stall_controller #(.MD_LATENCY(3), .CNT_W(4)) dut_s (
        .Clk(clk), .Reset(reset), .ID_VALID(id_valid), .ID_RS(id_rs), .ID_RT(id_rt),
        .ID_RS_USE(id_rs_use), .ID_RT_USE(id_rt_use), .ID_MD_START(id_md_start),
        .ID_HILO_READ(id_hilo_read), .EX_RD(ex_rd), .EX_RF_ENABLE(ex_rf_enable),
        .EX_LOAD_INSTR(ex_load_instr), .MEM_RD(mem_rd), .MEM_RF_ENABLE(mem_rf_enable),
        .WB_RD(wb_rd), .WB_RF_ENABLE(wb_rf_enable), .PC_LE(pc_le[1]), .IF_ID_LE(if_id_le[1]),
        .ID_EX_BUBBLE(bubble[1]), .MX1_SEL(mx1[1]), .MX2_SEL(mx2[1]), .MD_BUSY(md_busy[1]),
        .STALL_CYCLES(sc1)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: an accepted mult/div at edge number A keeps HI/LO busy while A < edges <= A+lat.
    int     lat_m [2] = '{4, 3};
    int     cw_m [2]  = '{32, 4};
    longint acc_e [2] = '{-1000, -1000};
    longint cnt_m [2] = '{0, 0};
    longint edge_n    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit busy_m(input int i);
        return (edge_n > acc_e[i]) && (edge_n <= acc_e[i] + lat_m[i]);
    endfunction

    function automatic bit stall_m(input bit b);
        bit lu, md;
        lu = id_valid && ex_load_instr && ex_rf_enable && (ex_rd != 0) &&
             ((id_rs_use && ex_rd == id_rs) || (id_rt_use && ex_rd == id_rt));
        md = id_valid && b && (id_hilo_read || id_md_start);
        return lu || md;
    endfunction

    function automatic logic [1:0] fwd_m(input logic [4:0] src, input logic u);
        logic [4:0] rd [3];
        bit         en [3];
        rd = '{ex_rd, mem_rd, wb_rd};
        en = '{ex_rf_enable && !ex_load_instr, mem_rf_enable, wb_rf_enable};
        if (!u || src == 0) return 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (en[k] && rd[k] == src) return 2'(k + 1);
        end
        return 2'd0;
    endfunction

    task automatic model_edge();
        bit b [2];
        bit st;
        longint maxv;
        for (int i = 0; i < 2; i++) b[i] = busy_m(i);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                acc_e[i] = -1000;
                cnt_m[i] = 0;
            end else begin
                st   = stall_m(b[i]);
                maxv = (longint'(1) << cw_m[i]) - 1;
                if (st && cnt_m[i] < maxv) cnt_m[i]++;
                if (!b[i] && id_valid && id_md_start && !st) acc_e[i] = edge_n;
            end
        end
        edge_n++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit st;
                st = reset ? 1'b0 : stall_m(busy_m(i));
                chk($sformatf("pc_le[%0d]", i), 64'(pc_le[i]), 64'(!st));
                chk($sformatf("if_id_le[%0d]", i), 64'(if_id_le[i]), 64'(!st));
                chk($sformatf("bubble[%0d]", i), 64'(bubble[i]), 64'(st));
                chk($sformatf("mx1[%0d]", i), 64'(mx1[i]), reset ? 64'd0 : 64'(fwd_m(id_rs, id_rs_use)));
                chk($sformatf("mx2[%0d]", i), 64'(mx2[i]), reset ? 64'd0 : 64'(fwd_m(id_rt, id_rt_use)));
                chk($sformatf("md_busy[%0d]", i), 64'(md_busy[i]), 64'(busy_m(i)));
            end
            chk("stall_cycles[0]", 64'(sc0), 64'(cnt_m[0]));
            chk("stall_cycles[1]", 64'(sc1), 64'(cnt_m[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_in();
        id_valid = 0; id_rs_use = 0; id_rt_use = 0; id_md_start = 0; id_hilo_read = 0;
        id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_rf_enable = 0; ex_load_instr = 0; mem_rf_enable = 0; wb_rf_enable = 0;
    endtask

    task automatic load_use_in();
        idle_in();
        id_valid = 1; ex_load_instr = 1; ex_rd = 8; ex_rf_enable = 1; id_rt = 8; id_rt_use = 1;
    endtask

    initial begin
        int n;
        reset = 1;
        idle_in();
        step();
        step();
        chk_en = 1;

        // Reset while a mult/div is in flight.
        reset = 0; id_valid = 1; id_md_start = 1;
        step();
        idle_in();
        #2 chk("busy_after_accept", 64'(md_busy[0]), 64'd1);
        step();
        reset = 1; id_valid = 1; id_rs = 5; id_rs_use = 1; ex_rd = 5; ex_rf_enable = 1;
        ex_load_instr = 1;
        #2 chk("reset_pc_le", 64'(pc_le[0]), 64'd1);
        chk("reset_mx1", 64'(mx1[0]), 64'd0);
        chk("reset_bubble", 64'(bubble[0]), 64'd0);
        step();
        reset = 0; idle_in();
        #2 chk("busy_after_reset", 64'(md_busy[0]), 64'd0);
        chk("count_after_reset", 64'(sc0), 64'd0);

        // Forwarding priority.
        step();
        ex_rd = 5; ex_rf_enable = 1; mem_rd = 5; mem_rf_enable = 1; id_rs = 5; id_rs_use = 1;
        #2 chk("fwd_ex", 64'(mx1[0]), 64'd1);
        step();
        ex_rf_enable = 0;
        #2 chk("fwd_mem", 64'(mx1[0]), 64'd2);
        step();
        idle_in(); id_rs_use = 1; ex_rf_enable = 1; mem_rf_enable = 1; wb_rf_enable = 1;
        #2 chk("fwd_r0", 64'(mx1[0]), 64'd0);

        // Load-use stall then release.
        step();
        load_use_in();
        #2 chk("lu_pc_le", 64'(pc_le[0]), 64'd0);
        chk("lu_if_id_le", 64'(if_id_le[0]), 64'd0);
        chk("lu_bubble", 64'(bubble[0]), 64'd1);
        chk("lu_mx2", 64'(mx2[0]), 64'd0);
        step();
        ex_rf_enable = 0; ex_load_instr = 0; ex_rd = 0; mem_rd = 8; mem_rf_enable = 1;
        #2 chk("lu_release", 64'(pc_le[0]), 64'd1);
        chk("lu_release_bubble", 64'(bubble[0]), 64'd0);
        chk("lu_release_mx2", 64'(mx2[0]), 64'd2);
        chk("lu_count", 64'(sc0), 64'd1);

        // mflo two cycles after mult acceptance.
        step();
        idle_in(); id_valid = 1; id_md_start = 1;
        step();
        idle_in();
        step();
        id_valid = 1; id_hilo_read = 1;
        #2 n = 0;
        while (pc_le[0] !== 1'b1 && n < 10) begin n++; step(); #2; end
        chk("mflo_stalls", 64'(n), 64'd3);
        chk("mflo_busy_done", 64'(md_busy[0]), 64'd0);
        chk("mflo_count", 64'(sc0), 64'd4);

        // Back-to-back mult.
        step();
        idle_in(); id_valid = 1; id_md_start = 1;
        step();
        #2 n = 0;
        while (pc_le[0] !== 1'b1 && n < 10) begin n++; step(); #2; end
        chk("b2b_stalls", 64'(n), 64'd4);
        step();
        idle_in();
        #2 n = 0;
        while (md_busy[0] === 1'b1 && n < 10) begin n++; step(); #2; end
        chk("b2b_busy_cycles", 64'(n), 64'd4);
        chk("b2b_count", 64'(sc0), 64'd8);

        // Counter saturation on the narrow instance.
        reset = 1;
        step();
        reset = 0; load_use_in();
        repeat (20) step();
        #2 chk("sat_narrow", 64'(sc1), 64'd15);
        chk("sat_wide", 64'(sc0), 64'd20);

        // Randomized traffic.
        repeat (3000) begin
            step();
            reset         = ($urandom_range(0, 63) == 0);
            id_valid      = ($urandom_range(0, 4) != 0);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            id_rs_use     = 1'($urandom);
            id_rt_use     = 1'($urandom);
            id_md_start   = ($urandom_range(0, 7) == 0);
            id_hilo_read  = ($urandom_range(0, 5) == 0);
            ex_rd         = 5'($urandom_range(0, 3));
            mem_rd        = 5'($urandom_range(0, 3));
            wb_rd         = 5'($urandom_range(0, 3));
            ex_rf_enable  = 1'($urandom);
            ex_load_instr = ($urandom_range(0, 3) == 0);
            mem_rf_enable = 1'($urandom);
            wb_rf_enable  = 1'($urandom);
        end
        step();
        #6;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
